uart_tx_arb: RTL

Round-robin arbiter that shares the single UART transmitter (`txd`) between `N_REQ` byte-stream requesters, for example the RX-loopback FIFO and an on-chip status/message source. It accepts one byte at a time from the granted requester and issues a one-cycle `frame_en` with stable `data_frame`. It then waits for `tx_done` and enforces an optional inter-frame gap before re-arbitrating. Packet locking keeps multi-byte messages contiguous, and a watchdog recovers from a transmitter that never reports `tx_done`.

---
 rtl/uart_tx_arb.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Round-robin arbiter sharing one UART transmitter between N_REQ byte-stream
// requesters. One byte is accepted at a time from the winning requester, handed
// to the transmitter with a one-cycle frame_en, and the arbiter then waits for
// tx_done (optionally followed by an idle gap) before arbitrating again.
// Multi-byte packets are kept contiguous by locking onto the owner until a byte
// marked last has been sent; a watchdog abandons a frame whose tx_done never
// arrives.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   req_valid    [N_REQ]        requester i presents a byte
//   req_data     [N_REQ*WIDTH]  byte of requester i at [i*WIDTH +: WIDTH]
//   req_last     [N_REQ]        byte closes the packet
//   req_ready    [N_REQ]        byte accepted this cycle (IDLE only, one-hot)
//   frame_en     start pulse to the transmitter
//   data_frame   [WIDTH]        byte to the transmitter, stable until tx_done
//   tx_done      transmitter finished the frame
//   grant        [N_REQ]        one-hot owner of current byte/packet
//   busy         not idle, or a packet lock is held
//   timeout_err  one-cycle pulse when the watchdog expires
module uart_tx_arb #(
   parameter int N_REQ       = 2,
   parameter int WIDTH       = 8,
   parameter int GAP_CYCLES  = 0,
   parameter int TIMEOUT_CYC = 131072
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   input  logic [N_REQ-1:0]       req_last,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   frame_en,
   output logic [WIDTH-1:0]       data_frame,
   input  logic                   tx_done,
   output logic [N_REQ-1:0]       grant,
   output logic                   busy,
   output logic                   timeout_err
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int SUM_W = PTR_W + 1;
   localparam int WD_W  = $clog2(TIMEOUT_CYC) + 1;
   localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

   localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(N_REQ - 1);
   localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYC);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT,
      ST_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]  owner_q, owner_d;
   logic              lock_q, lock_d;
   logic              last_q, last_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

   logic              win_found;
   logic [PTR_W-1:0]  win_idx;
   logic [SUM_W-1:0]  cand_sum;
   logic              wait_exit;
   logic              pkt_end;

   logic [WIDTH-1:0]  req_bytes [N_REQ];

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_bytes[gi] = req_data[gi*WIDTH +: WIDTH];
   end

   // Winner selection. While locked only the owner may win. Otherwise scan
   // rr_ptr, rr_ptr+1, ... with wrap; the loop runs from the far end back so
   // the last assignment is the nearest valid requester.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand_sum  = '0;
      if (lock_q) begin
         win_found = req_valid[owner_q];
         win_idx   = owner_q;
      end else begin
         for (int k = N_REQ - 1; k >= 0; k--) begin
            cand_sum = {1'b0, rr_ptr_q} + SUM_W'(k);
            if (cand_sum >= SUM_W'(N_REQ)) begin
               cand_sum = cand_sum - SUM_W'(N_REQ);
            end
            if (req_valid[cand_sum[PTR_W-1:0]]) begin
               win_found = 1'b1;
               win_idx   = cand_sum[PTR_W-1:0];
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      lock_d      = lock_q;
      last_d      = last_q;
      grant_d     = grant_q;
      data_d      = data_q;
      wd_cnt_d    = wd_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      req_ready   = '0;
      frame_en    = 1'b0;
      timeout_err = 1'b0;
      wait_exit   = 1'b0;
      pkt_end     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               req_ready[win_idx] = 1'b1;
               data_d             = req_bytes[win_idx];
               last_d             = req_last[win_idx];
               owner_d            = win_idx;
               grant_d            = '0;
               grant_d[win_idx]   = 1'b1;
               state_d            = ST_LOAD;
            end
         end

         ST_LOAD: begin
            frame_en = 1'b1;
            wd_cnt_d = '0;
            state_d  = ST_WAIT;
         end

         ST_WAIT: begin
            wd_cnt_d = wd_cnt_q + 1'b1;
            // tx_done wins over a watchdog expiring in the same cycle.
            if (tx_done) begin
               wait_exit = 1'b1;
               pkt_end   = last_q;
            end else if ((TIMEOUT_CYC != 0) && (wd_cnt_q == WD_LIMIT)) begin
               timeout_err = 1'b1;
               wait_exit   = 1'b1;
               pkt_end     = 1'b1;
            end
            if (wait_exit) begin
               if (pkt_end) begin
                  lock_d   = 1'b0;
                  rr_ptr_d = (owner_q == PTR_MAX) ? '0 : owner_q + 1'b1;
               end else begin
                  lock_d = 1'b1;
               end
               if (GAP_CYCLES > 0) begin
                  gap_cnt_d = '0;
                  state_d   = ST_GAP;
               end else begin
                  state_d = ST_IDLE;
                  if (pkt_end) begin
                     grant_d = '0;
                  end
               end
            end
         end

         ST_GAP: begin
            // lock_q was already updated on leaving WAIT, so a clear lock
            // here means the packet has ended and grant must drop.
            if (gap_cnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
               if (!lock_q) begin
                  grant_d = '0;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         owner_q   <= '0;
         lock_q    <= 1'b0;
         last_q    <= 1'b0;
         grant_q   <= '0;
         data_q    <= '0;
         wd_cnt_q  <= '0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         owner_q   <= owner_d;
         lock_q    <= lock_d;
         last_q    <= last_d;
         grant_q   <= grant_d;
         data_q    <= data_d;
         wd_cnt_q  <= wd_cnt_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   assign grant      = grant_q;
   assign data_frame = data_q;
   assign busy       = (state_q != ST_IDLE) || lock_q;

endmodule
